seg_decoder: RTL and testbench

SEG_DECODER -- requirements
Module: seg_decoder

---
 rtl/seg_decoder_if.sv | 26 ++
 rtl/seg_decoder.sv | 151 +++++++++++++++
 tb/tb_seg_decoder.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_decoder_if.sv
// Result channel of the 7-segment decoder: one decoded value per settled pattern.
// Handshake: a transfer happens on a rising edge where out_valid and out_ready are both high;
// once out_valid is raised, out_value/out_illegal/out_raw and out_valid itself stay constant until that transfer.
interface seg_decoder_if;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_value;
  logic       out_illegal;
  logic [7:0] out_raw;

  modport master (
    output out_valid,
    output out_value,
    output out_illegal,
    output out_raw,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_value,
    input  out_illegal,
    input  out_raw,
    output out_ready
  );
endinterface

// File: rtl/seg_decoder.sv
// Debounces an asynchronous 7-segment-plus-minus pattern, decodes it to a 4-bit
// two's-complement value (-4..+3) and presents each newly settled pattern once.
module seg_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk_2,
  input  logic             rst_n,
  input  logic [7:0]       seg_in,
  seg_decoder_if.master    res,
  output logic [ERR_W-1:0] err_count,
  output logic             fsm_state
);

  typedef enum logic {
    SETTLE  = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] sync1;
  logic [7:0] seg_s;
  logic [7:0] cand;
  logic [7:0] last_acc;
  logic       none_acc;
  logic [7:0] cnt;

  logic       load_cand;
  logic       clr_cnt;
  logic       inc_cnt;
  logic       present;
  logic       accept;

  logic [3:0] dec_value;
  logic       dec_illegal;

  assign res.out_valid = (state == PRESENT);
  assign fsm_state     = state;

  always_comb begin
    dec_value   = 4'h0;
    dec_illegal = 1'b0;
    case (cand)
      8'h3F:   dec_value = 4'h0;
      8'h06:   dec_value = 4'h1;
      8'h5B:   dec_value = 4'h2;
      8'h4F:   dec_value = 4'h3;
      8'h86:   dec_value = 4'hF;
      8'hDB:   dec_value = 4'hE;
      8'hCF:   dec_value = 4'hD;
      8'hE6:   dec_value = 4'hC;
      default: dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state <= SETTLE;
    end else begin
      state <= state_nxt;
    end
  end

  // seg_s changes are only looked at in SETTLE; PRESENT waits solely on the consumer.
  always_comb begin
    state_nxt = state;
    load_cand = 1'b0;
    clr_cnt   = 1'b0;
    inc_cnt   = 1'b0;
    present   = 1'b0;
    accept    = 1'b0;
    case (state)
      SETTLE: begin
        if (seg_s != cand) begin
          load_cand = 1'b1;
          clr_cnt   = 1'b1;
        end else if (cnt == CNT_LAST && (none_acc || cand != last_acc)) begin
          present   = 1'b1;
          state_nxt = PRESENT;
        end else begin
          inc_cnt = 1'b1;
        end
      end
      PRESENT: begin
        if (res.out_ready) begin
          accept    = 1'b1;
          clr_cnt   = 1'b1;
          state_nxt = SETTLE;
        end
      end
      default: state_nxt = SETTLE;
    endcase
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 8'h00;
      seg_s <= 8'h00;
    end else begin
      sync1 <= seg_in;
      seg_s <= sync1;
    end
  end

  // The counter saturates so a pattern held forever never wraps back to the trigger value.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      cand     <= 8'h00;
      cnt      <= 8'h00;
      last_acc <= 8'h00;
      none_acc <= 1'b1;
    end else begin
      if (load_cand) begin
        cand <= seg_s;
      end
      if (clr_cnt) begin
        cnt <= 8'h00;
      end else if (inc_cnt && cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
      if (accept) begin
        last_acc <= cand;
        none_acc <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      res.out_value   <= 4'h0;
      res.out_illegal <= 1'b0;
      res.out_raw     <= 8'h00;
    end else if (present) begin
      res.out_value   <= dec_value;
      res.out_illegal <= dec_illegal;
      res.out_raw     <= cand;
    end
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (accept && res.out_illegal && err_count != {ERR_W{1'b1}}) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_seg_decoder.sv
// Bench for seg_decoder: directed table vectors and multi-cycle corner cases,
// then randomized patterns checked against a transaction-level reference model.
module tb_seg_decoder;
  localparam int S = 4;

  logic       clk_2 = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] seg_in = 8'h00;
  logic       ready = 1'b0;
  logic [7:0] err_a;
  logic [1:0] err_b;
  logic       st_a;
  logic       st_b;

  seg_decoder_if if_a ();
  seg_decoder_if if_b ();
  assign if_a.out_ready = ready;
  assign if_b.out_ready = ready;

  seg_decoder #(.STABLE_CYCLES(S)) u_dut (
    .clk_2     (clk_2),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .res       (if_a.master),
    .err_count (err_a),
    .fsm_state (st_a)
  );

  seg_decoder #(.STABLE_CYCLES(S), .ERR_W(2)) u_dut2 (
    .clk_2     (clk_2),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .res       (if_b.master),
    .err_count (err_b),
    .fsm_state (st_b)
  );

  always #5 clk_2 = ~clk_2;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach summary, required finish");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [12:0] exp_q[$];
  logic [7:0]  last_acc;
  int          exp_err_a = 0;
  int          exp_err_b = 0;
  logic [7:0]  codes [8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h86, 8'hDB, 8'hCF, 8'hE6};

  typedef struct {
    logic [7:0] seg;
    logic [3:0] value;
    logic       illegal;
  } vec_t;
  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Codes 0..3 are the non-negative values; codes 4..7 are -1..-4.
  function automatic logic [4:0] ref_decode(input logic [7:0] p);
    for (int i = 0; i < 8; i++) begin
      if (p == codes[i]) return {1'b0, 4'(i < 4 ? i : 3 - i)};
    end
    return 5'b1_0000;
  endfunction

  function automatic logic [12:0] exp_word(input logic [7:0] p);
    return {ref_decode(p), p};
  endfunction

  function automatic logic [12:0] cur_a();
    return {if_a.out_illegal, if_a.out_value, if_a.out_raw};
  endfunction

  task automatic accept_model(input logic ill);
    if (ill) begin
      if (exp_err_a < 255) exp_err_a++;
      if (exp_err_b < 3) exp_err_b++;
    end
  endtask

  task automatic wait_pulse(input int budget, output int edges, output logic [12:0] got, output bit ok);
    edges = 0;
    ok    = 1'b0;
    got   = '0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk_2);
      edges++;
      @(negedge clk_2);
      if (if_a.out_valid) begin
        got = cur_a();
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk_2);
      if (if_a.out_valid && ready) n++;
    end
  endtask

  bit          hold_pend = 1'b0;
  logic [12:0] hold_val;
  bit          err_pend = 1'b0;

  task automatic cycle_mon();
    logic [12:0] cur;
    logic [12:0] e;
    @(posedge clk_2);
    #1 ready = 1'($urandom_range(0, 1));
    @(negedge clk_2);
    if (err_pend) begin
      check("rnd_err_a", err_a, exp_err_a);
      check("rnd_err_b", err_b, exp_err_b);
      err_pend = 1'b0;
    end
    cur = cur_a();
    if (hold_pend) begin
      check("rnd_valid_held", if_a.out_valid, 1);
      check("rnd_output_held", cur, hold_val);
    end
    hold_pend = 1'b0;
    if (if_a.out_valid) begin
      if (ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL rnd_unexpected: got %0h required no output", cur);
        end else begin
          e = exp_q.pop_front();
          check("rnd_result", cur, e);
          check("rnd_dut2_result", {if_b.out_illegal, if_b.out_value, if_b.out_raw}, e);
          accept_model(e[12]);
          err_pend = 1'b1;
        end
      end else begin
        hold_pend = 1'b1;
        hold_val  = cur;
      end
    end
  endtask

  initial begin
    int          edges;
    int          pulses;
    int          n;
    bit          ok;
    logic [12:0] got;
    logic [7:0]  p;
    logic [7:0]  g;

    vecs[0]  = '{8'h3F, 4'h0, 1'b0};
    vecs[1]  = '{8'h06, 4'h1, 1'b0};
    vecs[2]  = '{8'h5B, 4'h2, 1'b0};
    vecs[3]  = '{8'h4F, 4'h3, 1'b0};
    vecs[4]  = '{8'h86, 4'hF, 1'b0};
    vecs[5]  = '{8'hDB, 4'hE, 1'b0};
    vecs[6]  = '{8'hCF, 4'hD, 1'b0};
    vecs[7]  = '{8'hE6, 4'hC, 1'b0};
    vecs[8]  = '{8'h7F, 4'h0, 1'b1};
    vecs[9]  = '{8'h00, 4'h0, 1'b1};
    vecs[10] = '{8'h80, 4'h0, 1'b1};
    vecs[11] = '{8'hFF, 4'h0, 1'b1};
    vecs[12] = '{8'h01, 4'h0, 1'b1};

    // Reset state.
    rst_n  = 1'b0;
    seg_in = 8'h5B;
    ready  = 1'b1;
    repeat (3) @(posedge clk_2);
    #1;
    check("rst_valid_a", if_a.out_valid, 0);
    check("rst_valid_b", if_b.out_valid, 0);
    check("rst_value", if_a.out_value, 0);
    check("rst_illegal", if_a.out_illegal, 0);
    check("rst_raw", if_a.out_raw, 0);
    check("rst_err_a", err_a, 0);
    check("rst_err_b", err_b, 0);
    check("rst_state", st_a, 0);

    // Latency and single pulse for a held 0x5B.
    @(negedge clk_2);
    rst_n = 1'b1;
    wait_pulse(30, edges, got, ok);
    check("lat_seen", ok, 1);
    check("lat_edges", edges, S + 3);
    check("lat_result", got, {1'b0, 4'h2, 8'h5B});
    accept_model(1'b0);
    @(negedge clk_2);
    check("lat_one_cycle", if_a.out_valid, 0);
    count_pulses(30, n);
    check("lat_no_repeat", n, 0);

    // Code table, each pattern held 10 cycles.
    for (int i = 0; i < 13; i++) begin
      seg_in = vecs[i].seg;
      pulses = 0;
      got    = '0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk_2);
        if (if_a.out_valid && ready) begin
          pulses++;
          got = cur_a();
        end
      end
      accept_model(vecs[i].illegal);
      check($sformatf("tbl_pulses_%0h", vecs[i].seg), pulses, 1);
      check($sformatf("tbl_value_%0h", vecs[i].seg), got[11:8], vecs[i].value);
      check($sformatf("tbl_illegal_%0h", vecs[i].seg), got[12], vecs[i].illegal);
      check($sformatf("tbl_raw_%0h", vecs[i].seg), got[7:0], vecs[i].seg);
      check($sformatf("tbl_err_a_%0h", vecs[i].seg), err_a, exp_err_a);
      check($sformatf("tbl_err_b_%0h", vecs[i].seg), err_b, exp_err_b);
    end
    check("err_b_saturated", err_b, 3);

    // Short glitch away from a settled pattern produces nothing.
    seg_in = 8'h3F;
    count_pulses(12, n);
    check("glitch_settle", n, 1);
    seg_in = 8'h06;
    count_pulses(3, n);
    seg_in = 8'h3F;
    count_pulses(20, pulses);
    check("glitch_no_output", n + pulses, 0);

    // Backpressure: input change while presenting is ignored until accepted.
    ready  = 1'b0;
    seg_in = 8'h4F;
    repeat (20) @(negedge clk_2);
    check("bp_valid", if_a.out_valid, 1);
    check("bp_first", cur_a(), {1'b0, 4'h3, 8'h4F});
    seg_in = 8'hCF;
    repeat (10) @(negedge clk_2);
    check("bp_valid_kept", if_a.out_valid, 1);
    check("bp_value_kept", cur_a(), {1'b0, 4'h3, 8'h4F});
    ready = 1'b1;
    accept_model(1'b0);
    wait_pulse(30, edges, got, ok);
    check("bp_second_seen", ok, 1);
    check("bp_second", got, {1'b0, 4'hD, 8'hCF});
    accept_model(1'b0);

    // Reset during PRESENT, then 0x00 presented after release.
    @(negedge clk_2);
    ready  = 1'b0;
    seg_in = 8'h5B;
    wait_pulse(30, edges, got, ok);
    check("rp_present", ok, 1);
    @(negedge clk_2);
    rst_n = 1'b0;
    #1;
    check("rp_valid_drop", if_a.out_valid, 0);
    check("rp_err_a", err_a, 0);
    check("rp_err_b", err_b, 0);
    exp_err_a = 0;
    exp_err_b = 0;
    seg_in    = 8'h00;
    repeat (3) @(posedge clk_2);
    @(negedge clk_2);
    rst_n = 1'b1;
    ready = 1'b1;
    wait_pulse(30, edges, got, ok);
    check("rp_zero_seen", ok, 1);
    check("rp_zero", got, {1'b1, 4'h0, 8'h00});
    accept_model(1'b1);
    @(negedge clk_2);
    check("rp_err_after", err_a, exp_err_a);
    count_pulses(20, n);
    check("rp_no_repeat", n, 0);

    // Randomized patterns against the transaction-level model.
    last_acc = 8'h00;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) p = codes[$urandom_range(0, 7)];
      else p = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) p = last_acc;
      if ($urandom_range(0, 2) == 0) begin
        g = 8'($urandom_range(0, 255));
        if (g == p) g = ~p;
        seg_in = g;
        repeat ($urandom_range(1, S - 1)) cycle_mon();
      end
      seg_in = p;
      if (p != last_acc) begin
        exp_q.push_back(exp_word(p));
        last_acc = p;
      end
      n = 0;
      while ((exp_q.size() != 0 || n < 12) && n < 300) begin
        cycle_mon();
        n++;
      end
      if (exp_q.size() != 0) begin
        check("rnd_timeout", exp_q.size(), 0);
        exp_q.delete();
      end
    end
    cycle_mon();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
